hms_display_scan: RTL and testbench
===================================

# hms_display_scan

Six-digit multiplexed 7-segment display driver for the hours/minutes/seconds counter, sitting directly downstream of it. Consumes the binary `hrs`/`mins`/`sec` values, snapshots them once per display frame, converts each field to two BCD digits, and time-multiplexes them onto one shared segment bus with one-hot digit enables. All outputs are registered; the block has no handshake, since the counter outputs are level values sampled freely.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each digit stays lit; legal range ≥ 2.
- `clk`  in  1  system clock; same clock as the HMS counter.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hrs`  in  5  binary hours; valid range 0..23.
- `mins`  in  6  binary minutes; valid range 0..59.
- `sec`  in  6  binary seconds; valid range 0..59.
- `seg`  out  7  `{g,f,e,d,c,b,a}`, active-high segments of the currently enabled digit.
- `an`  out  6  digit enables, active-low, one-hot-low; `an[0]` is hours tens (leftmost), `an[5]` is seconds units.
- `dp`  out  1  decimal point, active-high; used as a field separator.

## Operation
- **Prescaler `pcnt`:** counts 0..SCAN_DIV-1 and wraps. Terminal count (`pcnt == SCAN_DIV-1`) produces `adv` for one cycle.
- **Digit index `didx`:** 0..5. Increments on `adv`; wraps 5→0.
- **Snapshot registers `s_hrs`, `s_mins`, `s_sec`:** load from the inputs on `adv` when `didx == 5`, i.e. at frame wrap. This prevents tearing within a frame.
- **Digit values:**
  - digit 0 / 1 = `s_hrs/10` / `s_hrs%10`
  - digit 2 / 3 = `s_mins/10` / `s_mins%10`
  - digit 4 / 5 = `s_sec/10` / `s_sec%10`
  - Division and modulo are by the constant 10 on ≤ 6-bit values, implemented combinationally.
- **Out-of-range fields:** if `s_hrs > 23`, `s_mins > 59`, or `s_sec > 59`, both digits of that field show a dash (segment g only). The other fields are unaffected.
- **Segment codes:**
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - dash = 1000000, blank = 0000000
- **Decimal point:** `dp = 1` when displaying digit 1 or digit 3; 0 otherwise.
- **Output drive:** exactly one `an` bit is low at any time after the first post-reset cycle. `seg` and `dp` always correspond to the digit whose `an` bit is low.

## Timing
- **Reset (asynchronous, `rst_n = 0`):**
  - `pcnt = 0`, `didx = 0`, snapshots = 0
  - `seg = 0`, `an = 6'b111111`, `dp = 0`
- **First cycle after reset release:** `an = 6'b111110`, `seg` = code for 0 (or blank with LZB enabled), since the snapshot is 0.
- **Latency:** one cycle from a `didx` change to `seg`/`an`/`dp` (registered outputs). Each digit is lit for exactly SCAN_DIV consecutive cycles; frame period is 6·SCAN_DIV cycles.
- **Snapshot latency:**
  - An input change becomes visible at the next frame start: ≤ 6·SCAN_DIV + 1 cycles.
  - An input change in the same cycle as the snapshot load is captured.
  - An input change one cycle later waits a full frame.
- **Reset mid-frame:** all state clears immediately and asynchronously; scanning restarts at digit 0 with a zero snapshot.

## Configuration
- **`HMS_DISP_LZB_EN` defined:** leading-zero blanking of the hours tens digit. When `s_hrs < 10`, digit 0 shows blank (0000000) and `an[0]` is still driven low for its slot, keeping slot timing uniform.
- **`HMS_DISP_LZB_EN` not defined:** digit 0 shows 0 for hours 0..9.
- Dash display for out-of-range hours overrides blanking in both builds.

## Structure
- **Shared package `hms_disp_pkg`:**
  - `NDIG = 6`
  - the eleven segment constants (`SEG_0`..`SEG_9`, `SEG_DASH`) and `SEG_BLANK`
  - `MAX_HRS = 23`, `MAX_MS = 59`
  - a `bin2bcd6` function returning `{tens, units}` for a 6-bit input
- **Sub-module `hms_bcd7seg`:** 4-bit BCD plus dash/blank controls → 7-bit segment code. Pure combinational; instantiated once on the selected digit.
- **Top level:** prescaler, digit index, snapshot, field select, and output registers.

## Test plan
All scenarios use SCAN_DIV = 4.
- **Reset values:** hold `rst_n = 0` with inputs 12:34:56 → `seg = 0`, `an = 111111`, `dp = 0`. Release; in the first frame all digits show `SEG_0`; each `an` slot lasts exactly 4 cycles in order 0..5.
- **Nominal digits:** inputs 12:34:56, second frame → `seg` per slot = 0000110, 1011011 (`dp = 1`), 1001111, 1100110 (`dp = 1`), 1101101, 1111101.
- **Tearing guard:** change `sec` 56→57 while slot 2 is lit → slot 5 still shows 6 this frame; 7 from the next frame.
- **Out-of-range fields:** `hrs = 25`, `mins = 60` → slots 0–3 show 1000000; seconds digits are unaffected.
- **Leading-zero blanking:** `hrs = 7` → slot 0 shows 0000000 with `HMS_DISP_LZB_EN` and 0111111 without; `an[0]` is low in both builds.
- **Reset mid-frame:** assert `rst_n` low during slot 3 → outputs clear in the same cycle; after release, scanning restarts at slot 0 with zeros.

Source files
------------

// File: rtl/hms_disp_pkg.sv
// hms_disp_pkg
// Shared constants and helpers for the six-digit HMS display scanner:
// digit count, 7-segment codes ({g,f,e,d,c,b,a}, active-high), valid field
// limits, and a 6-bit binary to two-digit BCD converter.
package hms_disp_pkg;

    localparam int NDIG = 6;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam int MAX_HRS = 23;
    localparam int MAX_MS  = 59;

    // Returns {tens, units}; inputs up to 63 so tens never exceeds 6.
    function automatic logic [7:0] bin2bcd6(input logic [5:0] i_bin);
        return {4'(i_bin / 6'd10), 4'(i_bin % 6'd10)};
    endfunction

endpackage

// File: rtl/hms_bcd7seg.sv
// hms_bcd7seg
// Combinational BCD digit to 7-segment encoder.
// Ports:
//   i_bcd   - BCD digit 0..9 (codes 10..15 render blank)
//   i_dash  - force a dash (segment g only); wins over i_blank
//   i_blank - force all segments off
//   o_seg   - {g,f,e,d,c,b,a}, active-high
module hms_bcd7seg (
    input  logic [3:0] i_bcd,
    input  logic       i_dash,
    input  logic       i_blank,
    output logic [6:0] o_seg
);
    import hms_disp_pkg::*;

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_dash) begin
            o_seg = SEG_DASH;
        end else if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/hms_display_scan.sv
// hms_display_scan
// Six-digit multiplexed 7-segment driver for an hours/minutes/seconds
// counter. Snapshots the time once per frame, converts each field to BCD and
// scans the digits onto a shared segment bus with one-hot-low digit enables.
// Optional feature macro: HMS_DISP_LZB_EN - blank the hours tens digit when
// the snapshot hours value is below 10 (the slot is still enabled).
// Parameters:
//   SCAN_DIV - clock cycles each digit stays lit (>= 2)
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   hrs   - binary hours 0..23
//   mins  - binary minutes 0..59
//   sec   - binary seconds 0..59
//   seg   - {g,f,e,d,c,b,a} of the enabled digit, active-high, registered
//   an    - digit enables, active-low; an[0] hours tens .. an[5] seconds units
//   dp    - decimal point, lit after hours units and minutes units
module hms_display_scan #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] hrs,
    input  logic [5:0] mins,
    input  logic [5:0] sec,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       dp
);
    import hms_disp_pkg::*;

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] r_pcnt;
    logic [2:0]    r_didx;
    logic [4:0]    r_s_hrs;
    logic [5:0]    r_s_mins;
    logic [5:0]    r_s_sec;
    logic [6:0]    r_seg;
    logic [5:0]    r_an;
    logic          r_dp;

    logic          w_adv;
    logic          w_frame_end;
    logic [5:0]    w_field;
    logic          w_oor;
    logic [7:0]    w_bcd;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [6:0]    w_seg;

    assign w_adv       = (r_pcnt == PW'(SCAN_DIV - 1));
    assign w_frame_end = w_adv && (r_didx == 3'(NDIG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
        end else if (w_adv) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_didx <= 3'd0;
        end else if (w_adv) begin
            r_didx <= (r_didx == 3'(NDIG - 1)) ? 3'd0 : r_didx + 3'd1;
        end
    end

    // Snapshot only at frame wrap so all six digits of a frame agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_hrs  <= '0;
            r_s_mins <= '0;
            r_s_sec  <= '0;
        end else if (w_frame_end) begin
            r_s_hrs  <= hrs;
            r_s_mins <= mins;
            r_s_sec  <= sec;
        end
    end

    always_comb begin
        w_field = 6'd0;
        w_oor   = 1'b0;
        case (r_didx)
            3'd0, 3'd1: begin
                w_field = {1'b0, r_s_hrs};
                w_oor   = (r_s_hrs > 5'(MAX_HRS));
            end
            3'd2, 3'd3: begin
                w_field = r_s_mins;
                w_oor   = (r_s_mins > 6'(MAX_MS));
            end
            default: begin
                w_field = r_s_sec;
                w_oor   = (r_s_sec > 6'(MAX_MS));
            end
        endcase
    end

    assign w_bcd   = bin2bcd6(w_field);
    // Even slots carry the tens digit, odd slots the units digit.
    assign w_digit = r_didx[0] ? w_bcd[3:0] : w_bcd[7:4];

`ifdef HMS_DISP_LZB_EN
    assign w_blank = (r_didx == 3'd0) && (r_s_hrs < 5'd10);
`else
    assign w_blank = 1'b0;
`endif

    hms_bcd7seg u_bcd7seg (
        .i_bcd   (w_digit),
        .i_dash  (w_oor),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= '1;
            r_dp  <= 1'b0;
        end else begin
            r_seg <= w_seg;
            r_an  <= ~(6'b000001 << r_didx);
            r_dp  <= (r_didx == 3'd1) || (r_didx == 3'd3);
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = r_dp;

endmodule

// File: tb/tb_hms_display_scan.sv
// tb_hms_display_scan
// Self-checking bench for hms_display_scan with SCAN_DIV = 4. A frame-level
// reference model tracks the edge count since reset, derives the lit slot
// arithmetically and recomputes digits from the captured time with /10 and
// %10. Build with HMS_DISP_LZB_EN defined to check the blanking variant.
module tb_hms_display_scan;

    localparam int D  = 4;
    localparam int FR = 6 * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] hrs = '0;
    logic [5:0] mins = '0;
    logic [5:0] sec = '0;
    logic [6:0] seg;
    logic [5:0] an;
    logic       dp;

    always #5 clk = ~clk;

    hms_display_scan #(.SCAN_DIV(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hrs   (hrs),
        .mins  (mins),
        .sec   (sec),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Model state: edges since reset release and the frame's captured time.
    int n = 0;
    int m_hrs = 0;
    int m_min = 0;
    int m_sec = 0;

    logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111};
    logic [5:0] an_tab [6] = '{6'b111110, 6'b111101, 6'b111011,
                               6'b110111, 6'b101111, 6'b011111};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, n, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int slot);
        int v;
        int lim;
        int d;
        case (slot / 2)
            0:       begin v = m_hrs; lim = 23; end
            1:       begin v = m_min; lim = 59; end
            default: begin v = m_sec; lim = 59; end
        endcase
        if (v > lim) return 7'b1000000;
`ifdef HMS_DISP_LZB_EN
        if (slot == 0 && v < 10) return 7'b0000000;
`endif
        d = (slot % 2 == 0) ? v / 10 : v % 10;
        return seg_tab[d];
    endfunction

    // One clock edge: capture at frame wrap takes effect after this edge's
    // outputs (which still show the previous frame's last digit).
    task automatic step();
        int slot;
        int c_h, c_m, c_s;
        bit cap;
        @(posedge clk);
        n++;
        cap = (n % FR == 0);
        c_h = int'(hrs);
        c_m = int'(mins);
        c_s = int'(sec);
        #1;
        slot = ((n - 1) / D) % 6;
        check_val("seg", 32'(seg), 32'(exp_seg(slot)));
        check_val("an",  32'(an),  32'(an_tab[slot]));
        check_val("dp",  32'(dp),  32'((slot == 1 || slot == 3) ? 1 : 0));
        if (cap) begin
            m_hrs = c_h;
            m_min = c_m;
            m_sec = c_s;
        end
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic set_in(input int h, input int m, input int s);
        hrs  = 5'(h);
        mins = 6'(m);
        sec  = 6'(s);
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_seg"}, 32'(seg), 32'(7'b0000000));
        check_val({tag, "_an"},  32'(an),  32'(6'b111111));
        check_val({tag, "_dp"},  32'(dp),  32'(1'b0));
    endtask

    initial begin
        set_in(12, 34, 56);
        rst_n = 1'b0;
        #23;
        check_cleared("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 0 shows the zero snapshot; frame 1 shows 12:34:56.
        run(2 * FR);

        // Tearing guard: seconds change while slot 2 is lit.
        run(2 * D + 1);
        set_in(12, 34, 57);
        run(FR - (2 * D + 1));
        run(FR);

        // Out-of-range hours and minutes.
        set_in(25, 60, 41);
        run(2 * FR);

        // Single-digit hours (blanking variant).
        set_in(7, 5, 9);
        run(2 * FR);

        // Change on the capture edge is taken; one edge later waits a frame.
        run(FR - 1);
        set_in(7, 42, 9);
        run(1);
        set_in(7, 43, 9);
        run(2 * FR);

        // Randomized input changes at arbitrary cycles, mostly in range.
        for (int i = 0; i < 20 * FR; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    set_in(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                           int'($urandom_range(0, 63)));
                else
                    set_in(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                           int'($urandom_range(0, 59)));
            end
            step();
        end

        // Reset mid-frame during slot 3.
        for (int i = 0; i < FR && (((n - 1) / D) % 6) != 3; i++) step();
        check_val("pre_rst_an", 32'(an), 32'(6'b110111));
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("midrst");
        @(posedge clk);
        #1;
        check_cleared("midrst_hold");
        set_in(9, 8, 7);
        n = 0;
        m_hrs = 0;
        m_min = 0;
        m_sec = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run(2 * FR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
